// File: rtl/can_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// can_arb_pkg
// Shared types and constants for the CAN register-port arbiter:
//   state_e      - arbiter FSM states (IDLE, ISSUE)
//   req_idx_t    - requester index (0 = host bus bridge, 1 = RX drain engine)
//   NUM_REQ      - number of requesters sharing the register port
//   LOCK_CNT_W   - lock counter width for the default LOCK_MAX
//   lock_cnt_width() - lock counter width for an arbitrary LOCK_MAX
// -----------------------------------------------------------------------------
package can_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef logic req_idx_t;

    localparam int NUM_REQ      = 2;
    localparam int LOCK_MAX_DEF = 16;
    localparam int LOCK_CNT_W   = $clog2(LOCK_MAX_DEF + 1);

    // Counter must be able to hold the value LOCK_MAX itself.
    function automatic int lock_cnt_width(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/can_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// can_reg_arbiter_if
// Bundles the requester-side and register-file-side signals of the arbiter.
//   Requester side : req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, lock_i
//                    -> ack_o, rvalid_o, rdata_o
//   Register side  : reg_re_o, reg_we_o, reg_addr_read_o, reg_addr_write_o,
//                    reg_data_in_o <- reg_data_out_i
// Modports:
//   slave  - the arbiter's view
//   master - the view of the surrounding logic (requesters + register file)
// -----------------------------------------------------------------------------
interface can_reg_arbiter_if
    import can_arb_pkg::*;
#(
    parameter int AW = 8
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] we_i;
    logic [AW-1:0]      addr0_i;
    logic [AW-1:0]      addr1_i;
    logic [7:0]         wdata0_i;
    logic [7:0]         wdata1_i;
    logic [NUM_REQ-1:0] lock_i;
    logic [NUM_REQ-1:0] ack_o;
    logic [NUM_REQ-1:0] rvalid_o;
    logic [7:0]         rdata_o;
    logic               reg_re_o;
    logic               reg_we_o;
    logic [AW-1:0]      reg_addr_read_o;
    logic [AW-1:0]      reg_addr_write_o;
    logic [7:0]         reg_data_in_o;
    logic [7:0]         reg_data_out_i;

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, lock_i,
        input  reg_data_out_i,
        output ack_o, rvalid_o, rdata_o,
        output reg_re_o, reg_we_o, reg_addr_read_o, reg_addr_write_o, reg_data_in_o
    );

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, lock_i,
        output reg_data_out_i,
        input  ack_o, rvalid_o, rdata_o,
        input  reg_re_o, reg_we_o, reg_addr_read_o, reg_addr_write_o, reg_data_in_o
    );

endinterface

// File: rtl/can_reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// can_arb_rr_pick
// Combinational winner selection for the two-requester register arbiter.
//   req        in  2   current requests
//   last_grant in  1   requester granted most recently
//   lock_held  in  1   last_grant had lock asserted during its strobe cycle
//   lock_cnt   in  CW  consecutive lock wins taken so far
//   winner     out 1   selected requester (meaningful only when req != 0)
// -----------------------------------------------------------------------------
module can_arb_rr_pick
    import can_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int CW       = 5
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last_grant,
    input  logic               lock_held,
    input  logic [CW-1:0]      lock_cnt,
    output req_idx_t           winner
);

    always_comb begin
        winner = last_grant;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            // Contention: the lock holder keeps the port until its budget is
            // spent, otherwise ownership alternates.
            2'b11:   winner = (lock_held && (lock_cnt < CW'(LOCK_MAX))) ? last_grant
                                                                        : ~last_grant;
            default: winner = last_grant;
        endcase
    end

endmodule

// File: rtl/can_reg_arbiter.sv
// -----------------------------------------------------------------------------
// can_reg_arbiter
// Shares the CAN core's single 8-bit register port between the host bus
// bridge (requester 0) and the RX-buffer drain engine (requester 1). Each
// access produces exactly one single-cycle re/we strobe, so side-effecting
// reads of status/interrupt registers happen once. Read data is registered.
//   aclk   in  clock
//   arstn  in  asynchronous active-low reset
//   bus    slave modport of can_reg_arbiter_if (requester + register signals)
// Timing: request sampled in IDLE at cycle N, strobe + ack at N+1,
// rvalid + rdata at N+2 (reads only). One access every two cycles.
// -----------------------------------------------------------------------------
module can_reg_arbiter
    import can_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 8
) (
    input  logic             aclk,
    input  logic             arstn,
    can_reg_arbiter_if.slave bus
);

    localparam int CW = lock_cnt_width(LOCK_MAX);

    state_e             state_q, state_d;
    req_idx_t           last_grant_q;
    req_idx_t           winner;
    logic               lock_held_q;
    logic [CW-1:0]      lock_cnt_q;
    logic               lock_win;
    logic               grant;
    logic               issue;

    req_idx_t           cmd_id_p0;
    logic               cmd_we_p0;
    logic [AW-1:0]      cmd_addr_p0;
    logic [7:0]         cmd_wdata_p0;

    req_idx_t           rd_id_p1;
    logic               vld_p1;
    logic [7:0]         rdata_p1;

    can_arb_rr_pick #(
        .LOCK_MAX (LOCK_MAX),
        .CW       (CW)
    ) u_pick (
        .req        (bus.req_i),
        .last_grant (last_grant_q),
        .lock_held  (lock_held_q),
        .lock_cnt   (lock_cnt_q),
        .winner     (winner)
    );

    assign grant = (state_q == IDLE) && (|bus.req_i);
    assign issue = (state_q == ISSUE);
    // Under contention the previous owner can only win again via the lock.
    assign lock_win = (&bus.req_i) && (winner == last_grant_q);

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req_i) state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: latch the winning command and update arbitration history.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
            lock_held_q  <= 1'b0;
            cmd_id_p0    <= 1'b0;
            cmd_we_p0    <= 1'b0;
            cmd_addr_p0  <= '0;
            cmd_wdata_p0 <= '0;
        end else begin
            if (grant) begin
                cmd_id_p0    <= winner;
                cmd_we_p0    <= bus.we_i[winner];
                cmd_addr_p0  <= winner ? bus.addr1_i  : bus.addr0_i;
                cmd_wdata_p0 <= winner ? bus.wdata1_i : bus.wdata0_i;
                last_grant_q <= winner;
                lock_cnt_q   <= lock_win ? (lock_cnt_q + CW'(1)) : '0;
            end
            // Lock intent is taken from the owner's strobe cycle.
            if (issue) begin
                lock_held_q <= bus.lock_i[cmd_id_p0];
            end
        end
    end

    // Stage p1: capture read data at the end of the strobe cycle.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            vld_p1   <= 1'b0;
            rd_id_p1 <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= issue && !cmd_we_p0;
            if (issue && !cmd_we_p0) begin
                rd_id_p1 <= cmd_id_p0;
                rdata_p1 <= bus.reg_data_out_i;
            end
        end
    end

    // Strobes decode straight from the state register so an async reset
    // removes them immediately.
    assign bus.reg_we_o         = issue &&  cmd_we_p0;
    assign bus.reg_re_o         = issue && !cmd_we_p0;
    assign bus.reg_addr_read_o  = cmd_addr_p0;
    assign bus.reg_addr_write_o = cmd_addr_p0;
    assign bus.reg_data_in_o    = cmd_wdata_p0;
    assign bus.ack_o            = issue  ? (2'b01 << cmd_id_p0) : 2'b00;
    assign bus.rvalid_o         = vld_p1 ? (2'b01 << rd_id_p1)  : 2'b00;
    assign bus.rdata_o          = rdata_p1;

endmodule

// File: tb/tb_can_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_can_reg_arbiter
// Directed bench for can_reg_arbiter (LOCK_MAX = 3). The register file is
// modelled as read data = read address XOR 0xC0.
// -----------------------------------------------------------------------------
module tb_can_reg_arbiter;

    logic aclk;
    logic arstn;
    int   n_chk;
    int   n_fail;
    int   re_cnt;
    int   overlap_cnt;
    int   re_start;
    logic [1:0] exp_ack;
    logic [7:0] exp_addr;

    can_reg_arbiter_if #(.AW(8)) bus ();

    can_reg_arbiter #(
        .LOCK_MAX (3),
        .AW       (8)
    ) dut (
        .aclk  (aclk),
        .arstn (arstn),
        .bus   (bus)
    );

    assign bus.reg_data_out_i = bus.reg_addr_read_o ^ 8'hC0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (bus.reg_re_o) re_cnt++;
        if (bus.reg_re_o && bus.reg_we_o) overlap_cnt++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; re_cnt = 0; overlap_cnt = 0;
        arstn = 1'b1;
        bus.req_i = 2'b00; bus.we_i = 2'b00; bus.lock_i = 2'b00;
        bus.addr0_i = 8'h00; bus.addr1_i = 8'h00;
        bus.wdata0_i = 8'h00; bus.wdata1_i = 8'h00;
        #2 arstn = 1'b0;
        tick(); tick();
        check("rst_ack",    32'(bus.ack_o), 0);
        check("rst_rvalid", 32'(bus.rvalid_o), 0);
        check("rst_rdata",  32'(bus.rdata_o), 0);
        check("rst_re",     32'(bus.reg_re_o), 0);
        check("rst_we",     32'(bus.reg_we_o), 0);
        check("rst_addr_r", 32'(bus.reg_addr_read_o), 0);
        check("rst_addr_w", 32'(bus.reg_addr_write_o), 0);
        check("rst_din",    32'(bus.reg_data_in_o), 0);
        arstn = 1'b1;
        tick();

        // Single write from requester 0
        bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr0_i = 8'h04; bus.wdata0_i = 8'h5A;
        tick();
        check("wr_we",     32'(bus.reg_we_o), 1);
        check("wr_re",     32'(bus.reg_re_o), 0);
        check("wr_addr_w", 32'(bus.reg_addr_write_o), 32'h04);
        check("wr_addr_r", 32'(bus.reg_addr_read_o), 32'h04);
        check("wr_din",    32'(bus.reg_data_in_o), 32'h5A);
        check("wr_ack",    32'(bus.ack_o), 32'h1);
        bus.req_i = 2'b00;
        tick();
        check("wr_we_off",  32'(bus.reg_we_o), 0);
        check("wr_ack_off", 32'(bus.ack_o), 0);
        check("wr_norv",    32'(bus.rvalid_o), 0);
        tick();
        check("wr_we_off2", 32'(bus.reg_we_o), 0);
        check("wr_norv2",   32'(bus.rvalid_o), 0);

        // Single read from requester 1
        bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr1_i = 8'h03;
        tick();
        check("rd_re",     32'(bus.reg_re_o), 1);
        check("rd_we",     32'(bus.reg_we_o), 0);
        check("rd_addr_r", 32'(bus.reg_addr_read_o), 32'h03);
        check("rd_ack",    32'(bus.ack_o), 32'h2);
        check("rd_norv_n1", 32'(bus.rvalid_o), 0);
        bus.req_i = 2'b00;
        tick();
        check("rd_rvalid", 32'(bus.rvalid_o), 32'h2);
        check("rd_rdata",  32'(bus.rdata_o), 32'hC3);
        check("rd_re_off", 32'(bus.reg_re_o), 0);
        tick();
        check("rd_rvalid_off", 32'(bus.rvalid_o), 0);
        check("rd_rdata_hold", 32'(bus.rdata_o), 32'hC3);

        // Simultaneous writes after a fresh reset, no lock: 0,1,0,1
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        tick();
        bus.req_i = 2'b11; bus.we_i = 2'b11; bus.lock_i = 2'b00;
        bus.addr0_i = 8'h10; bus.addr1_i = 8'h20;
        bus.wdata0_i = 8'hA0; bus.wdata1_i = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            exp_ack  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 8'h10 : 8'h20;
            tick();
            check($sformatf("rr_ack%0d", i),  32'(bus.ack_o), 32'(exp_ack));
            check($sformatf("rr_addr%0d", i), 32'(bus.reg_addr_write_o), 32'(exp_addr));
            check($sformatf("rr_we%0d", i),   32'(bus.reg_we_o), 1);
            if (i == 3) bus.req_i = 2'b00;
            tick();
            check($sformatf("rr_gap%0d", i),  32'(bus.ack_o), 0);
        end

        // Lock fairness: requester 1 locks, requester 0 joins after first grant
        bus.req_i = 2'b10; bus.we_i = 2'b01; bus.lock_i = 2'b10;
        bus.addr1_i = 8'h05; bus.addr0_i = 8'h07; bus.wdata0_i = 8'h11;
        tick();
        check("lk_ack0", 32'(bus.ack_o), 32'h2);
        bus.req_i = 2'b11;
        tick();
        check("lk_rv0", 32'(bus.rvalid_o), 32'h2);
        check("lk_rd0", 32'(bus.rdata_o), 32'hC5);
        for (int i = 1; i < 5; i++) begin
            exp_ack = (i < 4) ? 2'b10 : 2'b01;
            tick();
            check($sformatf("lk_ack%0d", i), 32'(bus.ack_o), 32'(exp_ack));
            if (i == 4) begin
                bus.req_i = 2'b00; bus.lock_i = 2'b00;
            end
            tick();
            check($sformatf("lk_rv%0d", i), 32'(bus.rvalid_o), (i < 4) ? 32'h2 : 32'h0);
        end

        // Reset during the strobe cycle of a read
        bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr0_i = 8'h08;
        tick();
        check("ar_re_on", 32'(bus.reg_re_o), 1);
        arstn = 1'b0;
        #1;
        check("ar_re_async", 32'(bus.reg_re_o), 0);
        check("ar_ack_async", 32'(bus.ack_o), 0);
        bus.req_i = 2'b00;
        tick();
        arstn = 1'b1;
        tick();
        check("ar_norv1", 32'(bus.rvalid_o), 0);
        tick();
        check("ar_norv2", 32'(bus.rvalid_o), 0);
        check("ar_noack", 32'(bus.ack_o), 0);
        bus.req_i = 2'b10; bus.addr1_i = 8'h09;
        tick();
        check("ar_new_re",  32'(bus.reg_re_o), 1);
        check("ar_new_ack", 32'(bus.ack_o), 32'h2);
        bus.req_i = 2'b00;
        tick();
        check("ar_new_rv", 32'(bus.rvalid_o), 32'h2);
        check("ar_new_rd", 32'(bus.rdata_o), 32'hC9);

        // Back-to-back reads from requester 0
        re_start = re_cnt;
        bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr0_i = 8'h0A;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bb_ack%0d", i), 32'(bus.ack_o), 32'h1);
            if (i == 4) bus.req_i = 2'b00;
            tick();
            check($sformatf("bb_gap%0d", i), 32'(bus.ack_o), 0);
            check($sformatf("bb_rv%0d", i),  32'(bus.rvalid_o), 32'h1);
            check($sformatf("bb_rd%0d", i),  32'(bus.rdata_o), 32'hCA);
        end
        tick();
        check("bb_re_count", 32'(re_cnt - re_start), 5);
        check("strobe_overlap", 32'(overlap_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/can_reg_arbiter.md
Name: can_reg_arbiter

Overview:
- Shares the controller's single 8-bit register port (re/we strobes, address, write data, read data) between two requesters.
  - Requester 0: the host bus bridge.
  - Requester 1: an internal RX-buffer drain engine.
- Serialises accesses, guarantees exactly one single-cycle strobe per access (reads of status/interrupt registers have side effects), and returns registered read data.
- Sits between the bus bridge / drain engine and the register file of the CAN core.

Parameters:
- LOCK_MAX, 16: maximum consecutive grants a locking requester may take while the other requester is waiting.
- AW, 8: register address width.

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- req_i  in  2  per-requester access request (bit n = requester n)
- we_i  in  2  per-requester write (1) / read (0)
- addr0_i  in  AW  requester 0 address
- addr1_i  in  AW  requester 1 address
- wdata0_i  in  8  requester 0 write data
- wdata1_i  in  8  requester 1 write data
- lock_i  in  2  requester n asks to keep ownership for its next access
- ack_o  out  2  one-cycle pulse: command of requester n issued this cycle
- rvalid_o  out  2  one-cycle pulse: read data valid for requester n
- rdata_o  out  8  read data, shared, qualified by rvalid_o
- reg_re_o  out  1  register read strobe
- reg_we_o  out  1  register write strobe
- reg_addr_read_o  out  AW  register read address
- reg_addr_write_o  out  AW  register write address
- reg_data_in_o  out  8  register write data
- reg_data_out_i  in  8  register read data (combinational from address)

Behaviour:
- Clock aclk; reset arstn, asynchronous, active-low.
- Reset values:
  - all strobes, ack_o, rvalid_o = 0; rdata_o = 0; addresses and write data = 0.
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie; lock_cnt = 0.
- FSM states:
  - IDLE: if req_i != 0, arbitrate, latch winner's we/addr/wdata into command registers, go to ISSUE. Otherwise stay.
  - ISSUE, exactly 1 cycle:
    - reg_we_o = latched we; reg_re_o = ~latched we.
    - Both address outputs carry the latched address; reg_data_in_o carries the latched wdata.
    - ack_o[winner] = 1.
    - For a read, capture reg_data_out_i into rdata_o at the end of this cycle.
    - Always return to IDLE.
  - rvalid_o[winner] = 1 in the cycle after ISSUE, reads only; rdata_o holds until the next read capture.
- Throughput: one access per 2 cycles. Read latency: req sampled at cycle N → strobe at N+1 → rvalid at N+2.
- Arbitration, evaluated only in IDLE:
  - One requester requesting → it wins.
  - Both requesting → the requester other than last_grant wins (round-robin), except the lock rule below.
  - Lock rule: if last_grant held lock_i=1 when its ISSUE cycle occurred and lock_cnt < LOCK_MAX, last_grant wins again.
  - lock_cnt increments on each such lock win; clears when the grant changes or on a non-locked grant.
  - At LOCK_MAX with the other requester waiting, grant goes to the other requester.
- Requests dropped before ack: not an error; only the value sampled in IDLE matters. Once in ISSUE the access completes regardless of req_i.
- A requester must hold req/we/addr/wdata stable until its ack_o pulse.
- Strobes are never asserted outside ISSUE; reg_re_o and reg_we_o are never both 1.
- Reset asserted mid-ISSUE: strobes drop immediately (async); no ack or rvalid is produced after reset release for that access.

Decomposition:
- Package can_arb_pkg:
  - state enum {IDLE, ISSUE}
  - requester-index typedef (1 bit)
  - NUM_REQ=2 localparam
  - lock counter width localparam, derived as $clog2(LOCK_MAX+1)
- Optional sub-module can_arb_rr_pick: combinational round-robin plus lock winner selection (inputs req, last_grant, lock_held, lock_cnt; output winner).

Test Plan:
- Single write: req_i=01, we=1, addr0=0x04, wdata0=0x5A → reg_we_o=1 for exactly 1 cycle with addr 0x04, data 0x5A; ack_o=01; no rvalid.
- Single read: req_i=10, we=0, addr1=0x03, reg_data_out_i=0xC3 → reg_re_o 1 cycle at N+1; rvalid_o=10 and rdata_o=0xC3 at N+2.
- Simultaneous requests after reset, both held 4 accesses, no lock → grant order 0,1,0,1; strobes never overlap.
- Lock fairness: LOCK_MAX=3, requester 1 locking with continuous reads, requester 0 requesting → grants 1,1,1,1 then 0. Covers initial grant plus 3 lock wins.
- Reset: arstn low during ISSUE of a read → reg_re_o falls asynchronously; after release no rvalid; first new request served normally.
- Back-to-back reads from one requester → ack every 2 cycles, exactly one reg_re_o pulse per access (count equals accesses).
